// File: rtl/binned_centroid.sv
// binned_centroid: accumulates set-pixel count and coordinate sums per binned frame,
// then divides sequentially to publish the blob centroid with a one-cycle strobe.
module binned_centroid #(
    parameter int H_BINS     = 320,
    parameter int V_BINS     = 180,
    parameter int MIN_PIXELS = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [8:0]  hcount_in,
    input  logic [7:0]  vcount_in,
    input  logic        pixel_in,
    output logic [8:0]  x_out,
    output logic [7:0]  y_out,
    output logic [15:0] count_out,
    output logic        detected_out,
    output logic        centroid_valid_out,
    output logic        frame_drop_out
);
    typedef enum logic [1:0] {ACCUM, DIVIDE, PUBLISH} state_t;

    state_t      state, state_next;
    logic [15:0] cnt, cnt_new, divisor;
    logic [24:0] sum_x, sum_x_new;
    logic [23:0] sum_y, sum_y_new;
    logic [24:0] quo_x, quo_y;
    logic [15:0] rem_x, rem_y;
    logic [16:0] trial_x, trial_y;
    logic        fit_x, fit_y, frame_start, frame_end;
    logic [4:0]  iter;
    logic        snap, step, last, publish, drop, det;

    assign frame_start = valid_in && hcount_in == 9'd0 && vcount_in == 8'd0;
    assign frame_end   = valid_in && hcount_in == 9'(H_BINS - 1) && vcount_in == 8'(V_BINS - 1);
    assign cnt_new     = cnt + 16'(pixel_in);
    assign sum_x_new   = sum_x + (pixel_in ? 25'(hcount_in) : 25'd0);
    assign sum_y_new   = sum_y + (pixel_in ? 24'(vcount_in) : 24'd0);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt   <= '0;
            sum_x <= '0;
            sum_y <= '0;
        end else if (frame_end) begin
            cnt   <= '0;
            sum_x <= '0;
            sum_y <= '0;
        end else if (frame_start) begin
            cnt   <= 16'(pixel_in);
            sum_x <= '0;
            sum_y <= '0;
        end else if (valid_in) begin
            cnt   <= cnt_new;
            sum_x <= sum_x_new;
            sum_y <= sum_y_new;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= ACCUM;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state == ACCUM  ? (frame_end ? DIVIDE : ACCUM) :
                     state == DIVIDE ? (last ? PUBLISH : DIVIDE) : ACCUM;
    end

    always_comb begin
        snap    = state == ACCUM && frame_end;
        step    = state == DIVIDE;
        last    = step && iter == 5'd24;
        publish = state == PUBLISH;
        drop    = frame_end && state != ACCUM;
    end

    // dividend shifts out MSB-first while quotient bits shift in at the bottom
    assign trial_x = {rem_x, quo_x[24]};
    assign trial_y = {rem_y, quo_y[24]};
    assign fit_x   = trial_x >= {1'b0, divisor};
    assign fit_y   = trial_y >= {1'b0, divisor};
    assign det     = divisor >= 16'(MIN_PIXELS);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            divisor <= '0;
            quo_x   <= '0;
            quo_y   <= '0;
            rem_x   <= '0;
            rem_y   <= '0;
            iter    <= '0;
        end else if (snap) begin
            divisor <= cnt_new;
            quo_x   <= sum_x_new;
            quo_y   <= 25'(sum_y_new);
            rem_x   <= '0;
            rem_y   <= '0;
            iter    <= '0;
        end else if (step) begin
            rem_x <= fit_x ? 16'(trial_x - {1'b0, divisor}) : trial_x[15:0];
            rem_y <= fit_y ? 16'(trial_y - {1'b0, divisor}) : trial_y[15:0];
            quo_x <= {quo_x[23:0], fit_x};
            quo_y <= {quo_y[23:0], fit_y};
            iter  <= iter + 5'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            x_out              <= '0;
            y_out              <= '0;
            count_out          <= '0;
            detected_out       <= 1'b0;
            centroid_valid_out <= 1'b0;
            frame_drop_out     <= 1'b0;
        end else begin
            centroid_valid_out <= publish;
            frame_drop_out     <= drop;
            if (publish) begin
                // gating also hides the meaningless quotient of a zero count
                x_out        <= det ? quo_x[8:0] : '0;
                y_out        <= det ? quo_y[7:0] : '0;
                count_out    <= divisor;
                detected_out <= det;
            end
        end
    end
endmodule
